mult_unit: RTL and testbench



---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_core.sv | 60 ++++++
 rtl/mult_unit.sv | 134 +++++++++++++
 tb/tb_mult_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg
//   Shared definitions for the iterative HI/LO multiplier:
//   - state encoding of the multiply sequencer
//   - default operand width and the matching iteration counter width
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_core.sv
// mult_core
//   Radix-2 shift-add datapath for an unsigned WIDTH x WIDTH multiply.
//   The accumulator starts as {0, multiplier}. Each step adds the multiplicand
//   into the upper half when the accumulator LSB (the current multiplier bit)
//   is set, then shifts the whole thing right one bit. The carry out of the
//   add becomes the new MSB, so no bit is lost. After WIDTH steps the
//   accumulator holds the full 2*WIDTH-bit product.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset, clears all state
//   load         in   capture operands and clear the product half
//   step         in   perform one add/shift iteration
//   multiplicand in   WIDTH-bit unsigned magnitude
//   multiplier   in   WIDTH-bit unsigned magnitude
//   product      out  2*WIDTH-bit accumulator contents
module mult_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;

    // Multiplicand gated by the current multiplier bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & acc_reg[0];
        end
    endgenerate

    // Carry out of the upper-half add lands in the MSB after the shift.
    assign sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign acc_next = {sum, acc_reg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_reg <= '0;
            acc_reg   <= '0;
        end else if (load) begin
            mcand_reg <= multiplicand;
            acc_reg   <= {{WIDTH{1'b0}}, multiplier};
        end else if (step) begin
            acc_reg   <= acc_next;
        end
    end

    assign product = acc_reg;

endmodule

// File: rtl/mult_unit.sv
// mult_unit
//   Iterative MULT/MULTU unit owning the HI/LO register pair.
//   Signed multiplies are done on magnitudes; the sign is reapplied in a
//   final FIX cycle that also commits the product to HI/LO. Total latency
//   from the start edge to the HI/LO update is WIDTH+1 cycles.
//   MTHI/MTLO write HI/LO directly, but only while idle and not starting.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   start_e    in   MULT/MULTU issued in execute
//   signed_e   in   1 = MULT (two's complement), 0 = MULTU
//   srca_e     in   multiplicand, also the MTHI/MTLO data
//   srcb_e     in   multiplier
//   mthi_e     in   MTHI in execute
//   mtlo_e     in   MTLO in execute
//   hi         out  HI register
//   lo         out  LO register
//   mult_done  out  1 = idle / result valid, 0 = multiply in flight
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_e,
    input  logic             signed_e,
    input  logic [WIDTH-1:0] srca_e,
    input  logic [WIDTH-1:0] srcb_e,
    input  logic             mthi_e,
    input  logic             mtlo_e,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_done
);

    localparam int COUNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mult_state_t        state_reg, state_next;
    logic [COUNT_W-1:0] count_reg;
    logic               sign_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;

    logic               load, step;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product;

    // Magnitudes. Negating the most negative value wraps back to 2^(W-1),
    // which is exactly the correct unsigned magnitude.
    assign mag_a = (signed_e && srca_e[WIDTH-1]) ? (~srca_e + 1'b1) : srca_e;
    assign mag_b = (signed_e && srcb_e[WIDTH-1]) ? (~srcb_e + 1'b1) : srcb_e;

    mult_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .step         (step),
        .multiplicand (mag_a),
        .multiplier   (mag_b),
        .product      (acc)
    );

    assign product = sign_reg ? (~acc + 1'b1) : acc;

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_e) begin
                    load       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (count_reg == COUNT_W'(WIDTH - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            sign_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                count_reg <= '0;
                sign_reg  <= signed_e & (srca_e[WIDTH-1] ^ srcb_e[WIDTH-1]);
            end else if (step) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    // HI/LO: the product commit in FIX has priority; moves are only taken
    // in IDLE and lose to a same-cycle start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (state_reg == FIX) begin
            hi_reg <= product[2*WIDTH-1:WIDTH];
            lo_reg <= product[WIDTH-1:0];
        end else if (state_reg == IDLE && !start_e) begin
            if (mthi_e) begin
                hi_reg <= srca_e;
            end
            if (mtlo_e) begin
                lo_reg <= srca_e;
            end
        end
    end

    assign hi        = hi_reg;
    assign lo        = lo_reg;
    assign mult_done = (state_reg == IDLE);

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit
//   Randomized self-checking bench for mult_unit. Expected HI/LO values come
//   from plain 64-bit arithmetic on the operands; MTHI/MTLO and reset are
//   tracked in a two-register model.
module tb_mult_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_e;
    logic          signed_e;
    logic [W-1:0]  srca_e;
    logic [W-1:0]  srcb_e;
    logic          mthi_e;
    logic          mtlo_e;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          mult_done;

    int            tests_run    = 0;
    int            tests_failed = 0;
    logic [W-1:0]  m_hi, m_lo;

    mult_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_e   (start_e),
        .signed_e  (signed_e),
        .srca_e    (srca_e),
        .srcb_e    (srcb_e),
        .mthi_e    (mthi_e),
        .mtlo_e    (mtlo_e),
        .hi        (hi),
        .lo        (lo),
        .mult_done (mult_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic sgn);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = 64'(a);
        ub = 64'(b);
        return ua * ub;
    endfunction

    // Called just after a falling edge with the unit idle; returns just after
    // the falling edge of the first idle cycle, so a following call issues
    // back-to-back.
    task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                           input logic with_mtlo);
        logic [63:0] p;
        int          cnt;
        bit          hold_ok;
        p        = ref_product(a, b, sgn);
        start_e  = 1'b1;
        signed_e = sgn;
        srca_e   = a;
        srcb_e   = b;
        mthi_e   = 1'b0;
        mtlo_e   = with_mtlo;
        @(posedge clk);
        cnt     = 0;
        hold_ok = 1'b1;
        while (cnt < 100) begin
            @(negedge clk);
            if (mult_done) break;
            cnt++;
            if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
            // Operand churn and stray moves while busy must have no effect.
            start_e = 1'b0;
            srca_e  = $urandom;
            srcb_e  = $urandom;
            mthi_e  = 1'($urandom_range(0, 1));
            mtlo_e  = 1'($urandom_range(0, 1));
        end
        start_e = 1'b0;
        mthi_e  = 1'b0;
        mtlo_e  = 1'b0;
        check("busy_len", 64'(cnt), 64'(W + 1));
        check("busy_hold", 64'(hold_ok), 64'(1));
        check("hi", 64'(hi), 64'(p[63:32]));
        check("lo", 64'(lo), 64'(p[31:0]));
        m_hi = p[63:32];
        m_lo = p[31:0];
        $display("[TB] %s %h * %h -> hi=%h lo=%h (cycles %0d)",
                 sgn ? "MULT " : "MULTU", a, b, hi, lo, cnt);
    endtask

    task automatic do_move(input logic hi_en, input logic lo_en, input logic [W-1:0] val);
        srca_e = val;
        mthi_e = hi_en;
        mtlo_e = lo_en;
        @(negedge clk);
        mthi_e = 1'b0;
        mtlo_e = 1'b0;
        if (hi_en) m_hi = val;
        if (lo_en) m_lo = val;
        check("move_hi", 64'(hi), 64'(m_hi));
        check("move_lo", 64'(lo), 64'(m_lo));
        check("move_done", 64'(mult_done), 64'(1));
        $display("[TB] move hi_en=%0b lo_en=%0b val=%h -> hi=%h lo=%h", hi_en, lo_en, val, hi, lo);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset    = 1'b1;
        start_e  = 1'b0;
        signed_e = 1'b0;
        srca_e   = '0;
        srcb_e   = '0;
        mthi_e   = 1'b0;
        mtlo_e   = 1'b0;
        m_hi     = '0;
        m_lo     = '0;
        repeat (2) @(negedge clk);
        check("rst_done", 64'(mult_done), 64'(1));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        do_move(1'b1, 1'b0, 32'h0000_1234);
        do_move(1'b0, 1'b1, 32'h0000_5678);
        do_move(1'b1, 1'b1, 32'hABCD_0123);

        do_mult(32'hFFFF_FFF9, 32'h0000_0006, 1'b1, 1'b0);
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_mult(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        do_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Start and MTLO together: the move is dropped, LO ends as product.
        do_mult(32'h0000_0009, 32'h0000_0009, 1'b0, 1'b1);

        // Back-to-back on the first idle cycle.
        do_mult(32'd2, 32'd3, 1'b0, 1'b0);
        do_mult(32'd4, 32'd5, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            do_mult(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset ten cycles into a multiply abandons it and clears HI/LO.
        start_e  = 1'b1;
        signed_e = 1'b0;
        srca_e   = 32'd1000;
        srcb_e   = 32'd1000;
        @(posedge clk);
        @(negedge clk);
        start_e = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy", 64'(mult_done), 64'(0));
        reset = 1'b1;
        #1;
        check("mid_rst_done", 64'(mult_done), 64'(1));
        check("mid_rst_hi", 64'(hi), 64'(0));
        check("mid_rst_lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        $display("[TB] reset during multiply -> hi=%h lo=%h done=%0b", hi, lo, mult_done);
        @(negedge clk);
        do_mult(32'd3, 32'd5, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
